// File: rtl/equation_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : equation_arbiter
// Purpose  : Shares one z = x*x + 2*x + y unit among NREQ requesters. It grants
//            at most one request per cycle and returns the tagged result through
//            a single registered valid/ready output stage.
// Options  : EQUATION_ARB_RR_EN selects round-robin arbitration. When it is
//            undefined, fixed priority is used and the lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module equation_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_x,
  input  logic [4*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [4:0]        rsp_z,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t         state_q;
  logic           rsp_valid_q;
  logic [4:0]     z_q;
  logic [IDW-1:0] id_q;

  logic           can_accept;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [1:0]     x_sel;
  logic [3:0]     y_sel;
  logic [4:0]     z_d;

`ifdef EQUATION_ARB_RR_EN
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic           hi_any;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;

  // Round-robin pick: the lowest valid index at or above the pointer wins.
  // If there is none, the search wraps to the lowest valid index overall.
  always_comb begin
    hi_any  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    gnt_any = |req_valid;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = IDW'(i);
        if (i >= int'(ptr_q)) begin
          hi_any = 1'b1;
          hi_idx = IDW'(i);
        end
      end
    end
    gnt_idx = hi_any ? hi_idx : lo_idx;
    ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
  end
`else
  // Fixed priority: the lowest-numbered valid requester wins.
  always_comb begin
    gnt_any = |req_valid;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_idx = IDW'(i);
      end
    end
  end
`endif

  // Route the winner's operands into the shared datapath and evaluate it.
  // The largest possible value is 9 + 6 + 15 = 30, so 5 bits are exact.
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(gnt_idx) == i) begin
        x_sel = req_x[2*i +: 2];
        y_sel = req_y[4*i +: 4];
      end
    end
    z_d = ({3'b000, x_sel} * {3'b000, x_sel}) + {2'b00, x_sel, 1'b0} + {1'b0, y_sel};
  end

  // Grant only when the output slot is free or is draining this cycle.
  // Grant is also blocked while reset is held.
  always_comb begin
    can_accept = rst_n & ((state_q == ST_EMPTY) | (rsp_valid_q & rsp_ready));
    req_ready  = (can_accept & gnt_any) ? (ONE_HOT0 << gnt_idx) : '0;
  end

  // Output-stage FSM: a new grant loads the result, including back-to-back
  // loads while draining. A drain with no new grant empties the stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      rsp_valid_q <= 1'b0;
      z_q         <= '0;
      id_q        <= '0;
`ifdef EQUATION_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else if (|req_ready) begin
      state_q     <= ST_FULL;
      rsp_valid_q <= 1'b1;
      z_q         <= z_d;
      id_q        <= gnt_idx;
`ifdef EQUATION_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end else if (rsp_ready) begin
      state_q     <= ST_EMPTY;
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = z_q;
  assign rsp_id    = id_q;
  assign busy      = rsp_valid_q | (|req_valid);

endmodule
`default_nettype wire

// File: tb/tb_equation_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_equation_arbiter
// Purpose  : Self-checking bench for equation_arbiter. A cycle-level reference
//            model is checked every cycle, and directed literal checks pin it.
//            It follows EQUATION_ARB_RR_EN to match the arbitration mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_equation_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_x;
  logic [4*NREQ-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [4:0]        rsp_z;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;
  logic              busy;

  equation_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the held result and the round-robin pointer.
  bit m_valid  = 1'b0;
  int m_z      = 0;
  int m_id     = 0;
  int m_p      = 0;
  int m_last_g = -1;
  int grant_log[$];
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Return the index that should be granted now, or -1 if none.
  function automatic int exp_grant();
    int start;
    int idx;
    if (rst_n !== 1'b1) return -1;
    if (m_valid && rsp_ready !== 1'b1) return -1;
`ifdef EQUATION_ARB_RR_EN
    start = m_p;
`else
    start = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = (start + k) % NREQ;
      if (req_valid[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  function automatic int eqn(input int i);
    int x;
    int y;
    x = int'(req_x[2*i +: 2]);
    y = int'(req_y[4*i +: 4]);
    return x * x + 2 * x + y;
  endfunction

  // Advance the model at each clock edge.
  always @(posedge clk) begin
    int g;
    g = exp_grant();
    m_last_g = g;
    if (rst_n !== 1'b1) begin
      m_valid = 1'b0;
      m_z = 0;
      m_id = 0;
      m_p = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_z = eqn(g);
      m_id = g;
      m_p = (g + 1) % NREQ;
      grant_log.push_back(g);
    end else if (rsp_ready === 1'b1) begin
      m_valid = 1'b0;
    end
  end

  // Compare the DUT against the model every cycle, on the falling edge.
  always @(negedge clk) begin
    int g;
    if (chk_en) begin
      g = exp_grant();
      chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_z", 32'(rsp_z), 32'(m_z));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("busy", 32'(busy), 32'(m_valid | (|req_valid)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int x, input int y);
    req_x[2*i +: 2] = 2'(x);
    req_y[4*i +: 4] = 4'(y);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b0;

    // Reset with all requesters asserting.
    req_valid = 4'hF;
    @(posedge clk);
    chk_en = 1'b1;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_z", 32'(rsp_z), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    grant_log.delete();
    tick();
    chk("first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd0);
    chk("first_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    tick();

    // Single request, maximum value, then zero.
    set_op(2, 3, 15);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_z30", 32'(rsp_z), 32'd30);
    chk("single_id2", 32'(rsp_id), 32'd2);
    set_op(2, 0, 0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("single_z0", 32'(rsp_z), 32'd0);
    tick();

    // Backpressure: the result is held, no grants are made, and it is delivered once.
    rsp_ready = 1'b0;
    set_op(1, 2, 5);
    req_valid = 4'b0010;
    tick();
    set_op(3, 0, 0);
    req_valid = 4'b1000;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_z13", 32'(rsp_z), 32'd13);
      chk("bp_id1", 32'(rsp_id), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      if (k < 2) tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    tick();
    chk("bp_no_dup", 32'(rsp_valid), 32'd0);

    // Contention with all four requesters held valid.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, i % 4, i + 1);
    grant_log.delete();
    req_valid = 4'hF;
    repeat (5) tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
`ifdef EQUATION_ARB_RR_EN
      chk("contend_order", (grant_log.size() > k) ? grant_log[k] : -1, 32'(k % 4));
`else
      chk("contend_order", (grant_log.size() > k) ? grant_log[k] : -1, 32'd0);
`endif
    end
    tick();

    // Back-to-back results with no bubble.
    do_reset();
    rsp_ready = 1'b1;
    set_op(0, 1, 0);
    set_op(3, 2, 1);
    req_valid = 4'b1001;
    tick();
    req_valid = 4'b1000;
    chk("b2b_v0", 32'(rsp_valid), 32'd1);
    chk("b2b_z3", 32'(rsp_z), 32'd3);
    chk("b2b_id0", 32'(rsp_id), 32'd0);
    tick();
    req_valid = '0;
    chk("b2b_v1", 32'(rsp_valid), 32'd1);
    chk("b2b_z9", 32'(rsp_z), 32'd9);
    chk("b2b_id3", 32'(rsp_id), 32'd3);
    tick();

    // Reset while full discards the held result and clears the pointer.
    rsp_ready = 1'b0;
    set_op(2, 3, 15);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("mid_full_z30", 32'(rsp_z), 32'd30);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_z", 32'(rsp_z), 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    chk("mid_never_delivered", 32'(rsp_valid), 32'd0);
    grant_log.delete();
    req_valid = 4'hF;
    tick();
    req_valid = '0;
    chk("mid_ptr_zero", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd0);
    tick();

    // Randomized traffic. Requests are held until granted or occasionally dropped.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && m_last_g == i) req_valid[i] = 1'b0;
        else if (req_valid[i] && ($urandom % 16 == 0)) req_valid[i] = 1'b0;
        else if (!req_valid[i] && ($urandom % 3 == 0)) begin
          set_op(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom % 4) != 0;
      rst_n = ($urandom % 150) != 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
